// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC and fetches words over a req/ack bus.
// Optional fetch timeout enabled by defining IFETCH_TIMEOUT_EN.
module instr_fetch #(
   parameter int unsigned       ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [ADDR_W-1:0] IMEM_LO  = '0,
   parameter logic [ADDR_W-1:0] IMEM_HI  = ADDR_W'(32'h0000_FFFC),
   parameter int unsigned       TIMEOUT  = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              pc_inc,
   input  logic              pc_load,
   input  logic [ADDR_W-1:0] pc_load_value,
   output logic [ADDR_W-1:0] imem_addr,
   output logic              imem_req,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   input  logic              imem_fault,
   output logic [31:0]       instruction,
   output logic              wait_instr,
   output logic              instr_segv,
   output logic [ADDR_W-1:0] pc
);

   typedef enum logic [2:0] {
      ISSUE,
      WAIT,
      VALID,
      FLUSH,
      FAULT
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       instr_q, instr_d;
   logic              wait_q, wait_d;
   logic              segv_q, segv_d;
   logic              req_q, req_d;
   logic              pc_bad;

`ifdef IFETCH_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT) + 1;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          tmo;
   assign tmo = (cnt_q == CW'(TIMEOUT - 1));
`endif

   // single unsigned compare covers both range ends
   assign pc_bad = ((pc_q - IMEM_LO) > (IMEM_HI - IMEM_LO))
                || (pc_q[1:0] != 2'b00);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ISSUE;
         pc_q    <= RESET_PC;
         addr_q  <= RESET_PC;
         instr_q <= '0;
         wait_q  <= 1'b1;
         segv_q  <= 1'b0;
         req_q   <= 1'b0;
`ifdef IFETCH_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         instr_q <= instr_d;
         wait_q  <= wait_d;
         segv_q  <= segv_d;
         req_q   <= req_d;
`ifdef IFETCH_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      addr_d  = addr_q;
      instr_d = instr_q;
      wait_d  = wait_q;
      segv_d  = segv_q;
      req_d   = req_q;
`ifdef IFETCH_TIMEOUT_EN
      cnt_d   = cnt_q;
`endif
      unique case (state_q)
         ISSUE: begin
            if (pc_load) begin
               pc_d   = pc_load_value;
               wait_d = 1'b1;
               segv_d = 1'b0;
            end else if (pc_bad) begin
               state_d = FAULT;
               segv_d  = 1'b1;
               wait_d  = 1'b1;
               req_d   = 1'b0;
            end else begin
               state_d = WAIT;
               req_d   = 1'b1;
               addr_d  = pc_q;
`ifdef IFETCH_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         WAIT: begin
            if (pc_load) begin
               pc_d   = pc_load_value;
               wait_d = 1'b1;
               segv_d = 1'b0;
               if (imem_ack) begin
                  state_d = ISSUE;
                  req_d   = 1'b0;
               end else begin
                  state_d = FLUSH;
               end
            end else if (imem_ack) begin
               req_d = 1'b0;
               if (imem_fault) begin
                  state_d = FAULT;
                  segv_d  = 1'b1;
               end else begin
                  state_d = VALID;
                  instr_d = imem_rdata;
                  wait_d  = 1'b0;
               end
            end
`ifdef IFETCH_TIMEOUT_EN
            else if (tmo) begin
               state_d = FAULT;
               segv_d  = 1'b1;
               req_d   = 1'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         VALID: begin
            if (pc_load) begin
               state_d = ISSUE;
               pc_d    = pc_load_value;
               wait_d  = 1'b1;
               segv_d  = 1'b0;
            end else if (pc_inc) begin
               state_d = ISSUE;
               pc_d    = pc_q + ADDR_W'(4);
               wait_d  = 1'b1;
            end
         end
         FLUSH: begin
            if (pc_load) begin
               pc_d = pc_load_value;
            end
            // the outstanding beat belongs to the old pc and is dropped
            if (imem_ack) begin
               state_d = ISSUE;
               req_d   = 1'b0;
            end
         end
         FAULT: begin
            if (pc_load) begin
               state_d = ISSUE;
               pc_d    = pc_load_value;
               wait_d  = 1'b1;
               segv_d  = 1'b0;
            end
         end
         default: begin
            state_d = ISSUE;
            req_d   = 1'b0;
         end
      endcase
   end

   always_comb begin
      imem_addr   = addr_q;
      imem_req    = req_q;
      instruction = instr_q;
      wait_instr  = wait_q;
      instr_segv  = segv_q;
      pc          = pc_q;
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: fetch, advance, redirect, faults, reset.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        pc_inc = 1'b0;
   logic        pc_load = 1'b0;
   logic [31:0] pc_load_value = '0;
   logic [31:0] imem_addr;
   logic        imem_req;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        imem_fault = 1'b0;
   logic [31:0] instruction;
   logic        wait_instr;
   logic        instr_segv;
   logic [31:0] pc;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   instr_fetch dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .pc_inc        (pc_inc),
      .pc_load       (pc_load),
      .pc_load_value (pc_load_value),
      .imem_addr     (imem_addr),
      .imem_req      (imem_req),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .imem_fault    (imem_fault),
      .instruction   (instruction),
      .wait_instr    (wait_instr),
      .instr_segv    (instr_segv),
      .pc            (pc)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      // reset state
      tick;
      chk("rst_pc", pc, 32'h0);
      chk("rst_wait", {31'b0, wait_instr}, 32'h1);
      chk("rst_segv", {31'b0, instr_segv}, 32'h0);
      chk("rst_req", {31'b0, imem_req}, 32'h0);
      chk("rst_instr", instruction, 32'h0);
      reset_n = 1'b1;

      // first fetch, ack after 3 req cycles
      tick;
      chk("f0_req", {31'b0, imem_req}, 32'h1);
      chk("f0_addr", imem_addr, 32'h0);
      tick;
      chk("f0_hold_req", {31'b0, imem_req}, 32'h1);
      chk("f0_hold_wait", {31'b0, wait_instr}, 32'h1);
      tick;
      chk("f0_hold2_req", {31'b0, imem_req}, 32'h1);
      imem_ack = 1'b1;
      imem_rdata = 32'h8080_1234;
      tick;
      imem_ack = 1'b0;
      chk("f0_instr", instruction, 32'h8080_1234);
      chk("f0_wait", {31'b0, wait_instr}, 32'h0);
      chk("f0_req_drop", {31'b0, imem_req}, 32'h0);
      chk("f0_pc", pc, 32'h0);
      tick;
      chk("f0_stable", instruction, 32'h8080_1234);

      // advance
      pc_inc = 1'b1;
      tick;
      pc_inc = 1'b0;
      chk("inc_pc", pc, 32'h4);
      chk("inc_wait", {31'b0, wait_instr}, 32'h1);
      tick;
      chk("inc_req", {31'b0, imem_req}, 32'h1);
      chk("inc_addr", imem_addr, 32'h4);
      pc_inc = 1'b1;
      tick;
      pc_inc = 1'b0;
      chk("inc_ign_pc", pc, 32'h4);

      // redirect while waiting, stale beat discarded
      pc_load = 1'b1;
      pc_load_value = 32'h100;
      tick;
      pc_load = 1'b0;
      chk("fl_pc", pc, 32'h100);
      chk("fl_req", {31'b0, imem_req}, 32'h1);
      chk("fl_addr", imem_addr, 32'h4);
      tick;
      chk("fl_addr2", imem_addr, 32'h4);
      imem_ack = 1'b1;
      imem_rdata = 32'h0000_DEAD;
      tick;
      imem_ack = 1'b0;
      chk("fl_req_drop", {31'b0, imem_req}, 32'h0);
      chk("fl_discard", instruction, 32'h8080_1234);
      chk("fl_wait", {31'b0, wait_instr}, 32'h1);
      tick;
      chk("fl_new_req", {31'b0, imem_req}, 32'h1);
      chk("fl_new_addr", imem_addr, 32'h100);
      imem_ack = 1'b1;
      imem_rdata = 32'hCAFE_F00D;
      tick;
      imem_ack = 1'b0;
      chk("fl_instr", instruction, 32'hCAFE_F00D);
      chk("fl_valid", {31'b0, wait_instr}, 32'h0);

      // out-of-range target
      pc_load = 1'b1;
      pc_load_value = 32'h2_0000;
      tick;
      pc_load = 1'b0;
      chk("oor_pc", pc, 32'h2_0000);
      chk("oor_req0", {31'b0, imem_req}, 32'h0);
      tick;
      chk("oor_segv", {31'b0, instr_segv}, 32'h1);
      chk("oor_req", {31'b0, imem_req}, 32'h0);
      chk("oor_wait", {31'b0, wait_instr}, 32'h1);
      pc_inc = 1'b1;
      tick;
      pc_inc = 1'b0;
      chk("oor_persist", {31'b0, instr_segv}, 32'h1);
      chk("oor_inc_ign", pc, 32'h2_0000);

      // misaligned target
      pc_load = 1'b1;
      pc_load_value = 32'h6;
      tick;
      pc_load = 1'b0;
      chk("mis_clr", {31'b0, instr_segv}, 32'h0);
      tick;
      chk("mis_segv", {31'b0, instr_segv}, 32'h1);
      chk("mis_req", {31'b0, imem_req}, 32'h0);

      // recover to 8, then bus fault
      pc_load = 1'b1;
      pc_load_value = 32'h8;
      tick;
      pc_load = 1'b0;
      chk("rec_segv", {31'b0, instr_segv}, 32'h0);
      chk("rec_pc", pc, 32'h8);
      tick;
      chk("rec_req", {31'b0, imem_req}, 32'h1);
      chk("rec_addr", imem_addr, 32'h8);
      imem_ack = 1'b1;
      imem_fault = 1'b1;
      tick;
      imem_ack = 1'b0;
      imem_fault = 1'b0;
      chk("bus_segv", {31'b0, instr_segv}, 32'h1);
      chk("bus_req", {31'b0, imem_req}, 32'h0);

      // async reset mid-WAIT
      pc_load = 1'b1;
      pc_load_value = 32'h8;
      tick;
      pc_load = 1'b0;
      tick;
      chk("mw_req", {31'b0, imem_req}, 32'h1);
      reset_n = 1'b0;
      #1;
      chk("ar_pc", pc, 32'h0);
      chk("ar_req", {31'b0, imem_req}, 32'h0);
      chk("ar_segv", {31'b0, instr_segv}, 32'h0);
      chk("ar_wait", {31'b0, wait_instr}, 32'h1);
      tick;
      reset_n = 1'b1;

      // minimum latency: ack in the first req cycle
      tick;
      chk("lat_req", {31'b0, imem_req}, 32'h1);
      chk("lat_wait1", {31'b0, wait_instr}, 32'h1);
      imem_ack = 1'b1;
      imem_rdata = 32'h1111_2222;
      tick;
      imem_ack = 1'b0;
      chk("lat_wait0", {31'b0, wait_instr}, 32'h0);
      chk("lat_instr", instruction, 32'h1111_2222);

      // pc_load beats pc_inc; top legal address
      pc_inc = 1'b1;
      pc_load = 1'b1;
      pc_load_value = 32'h0000_FFFC;
      tick;
      pc_inc = 1'b0;
      pc_load = 1'b0;
      chk("pri_pc", pc, 32'h0000_FFFC);
      tick;
      chk("hi_req", {31'b0, imem_req}, 32'h1);
      chk("hi_addr", imem_addr, 32'h0000_FFFC);
      imem_ack = 1'b1;
      imem_rdata = 32'h0000_0013;
      tick;
      imem_ack = 1'b0;
      chk("hi_instr", instruction, 32'h0000_0013);
      pc_inc = 1'b1;
      tick;
      pc_inc = 1'b0;
      chk("hi_inc_pc", pc, 32'h0001_0000);
      tick;
      chk("hi_over_segv", {31'b0, instr_segv}, 32'h1);
      chk("hi_over_req", {31'b0, imem_req}, 32'h0);

`ifdef IFETCH_TIMEOUT_EN
      // no ack: fault 16 cycles after req rises
      pc_load = 1'b1;
      pc_load_value = 32'h0;
      tick;
      pc_load = 1'b0;
      tick;
      chk("to_req", {31'b0, imem_req}, 32'h1);
      for (int i = 1; i < 16; i++) begin
         tick;
         chk("to_pre_segv", {31'b0, instr_segv}, 32'h0);
      end
      tick;
      chk("to_segv", {31'b0, instr_segv}, 32'h1);
      chk("to_req_drop", {31'b0, imem_req}, 32'h0);
      imem_ack = 1'b1;
      imem_rdata = 32'h7777_7777;
      tick;
      imem_ack = 1'b0;
      chk("to_late_segv", {31'b0, instr_segv}, 32'h1);
      chk("to_late_wait", {31'b0, wait_instr}, 32'h1);
      chk("to_late_instr", instruction, 32'h0000_0013);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
